// File: rtl/comet_ii_pkg.sv
// comet_ii_pkg: shared definitions for the COMET II execute controller.
// Provides datapath widths, ALU op codes, FR bit positions, the controller
// state enum, the writeback payload struct and small op-decode helpers.
package comet_ii_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned FR_W   = 3;
   localparam int unsigned CNT_W  = 32;

   // FR layout {OF,SF,ZF}
   localparam int unsigned FR_OF = 2;
   localparam int unsigned FR_SF = 1;
   localparam int unsigned FR_ZF = 0;

   localparam logic [OP_W-1:0] OP_LD   = 4'h0;
   localparam logic [OP_W-1:0] OP_ADDA = 4'h1;
   localparam logic [OP_W-1:0] OP_SUBA = 4'h2;
   localparam logic [OP_W-1:0] OP_ADDL = 4'h3;
   localparam logic [OP_W-1:0] OP_SUBL = 4'h4;
   localparam logic [OP_W-1:0] OP_AND  = 4'h5;
   localparam logic [OP_W-1:0] OP_OR   = 4'h6;
   localparam logic [OP_W-1:0] OP_XOR  = 4'h7;
   localparam logic [OP_W-1:0] OP_CPA  = 4'h8;
   localparam logic [OP_W-1:0] OP_CPL  = 4'h9;
   localparam logic [OP_W-1:0] OP_SLA  = 4'hA;
   localparam logic [OP_W-1:0] OP_SRA  = 4'hB;
   localparam logic [OP_W-1:0] OP_SLL  = 4'hC;
   localparam logic [OP_W-1:0] OP_SRL  = 4'hD;
   localparam logic [OP_W-1:0] OP_NOP  = 4'hF;

   // Largest meaningful shift distance for a 16-bit word
   localparam logic [DATA_W-1:0] SHIFT_MAX = DATA_W'(16);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_e;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
   } wb_payload_t;

   // Ops that write a GR result
   function automatic logic op_has_wb(input logic [OP_W-1:0] op);
      logic r;
      r = 1'b0;
      case (op)
         OP_LD, OP_ADDA, OP_SUBA, OP_ADDL, OP_SUBL, OP_AND, OP_OR, OP_XOR,
         OP_SLA, OP_SRA, OP_SLL, OP_SRL: r = 1'b1;
         default:                        r = 1'b0;
      endcase
      return r;
   endfunction

   // Ops that update FR: every writeback op plus the compares
   function automatic logic op_sets_fr(input logic [OP_W-1:0] op);
      return op_has_wb(op) || (op == OP_CPA) || (op == OP_CPL);
   endfunction

   function automatic logic op_is_shift(input logic [OP_W-1:0] op);
      return (op == OP_SLA) || (op == OP_SRA) || (op == OP_SLL) || (op == OP_SRL);
   endfunction

   function automatic logic [DATA_W-1:0] shift_clamp(input logic [DATA_W-1:0] b);
      return (b > SHIFT_MAX) ? SHIFT_MAX : b;
   endfunction

endpackage

// File: rtl/comet_ii_exec_wb_reg.sv
// comet_ii_exec_wb_reg: writeback index/data register with valid/ready handshake.
// Ports: clk, rst_n (async active-low); load/load_data capture a new result
// and raise wb_valid; wb_ready completes the handshake; wb_valid/wb_idx/wb_data
// are the registered writeback outputs, held stable until accepted.
module comet_ii_exec_wb_reg
   import comet_ii_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  wb_payload_t       load_data,
   input  logic              wb_ready,
   output logic              wb_valid,
   output logic [IDX_W-1:0]  wb_idx,
   output logic [DATA_W-1:0] wb_data
);

   // Capture on load; drop valid once the consumer takes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid <= 1'b0;
         wb_idx   <= '0;
         wb_data  <= '0;
      end else if (load) begin
         wb_valid <= 1'b1;
         wb_idx   <= load_data.idx;
         wb_data  <= load_data.data;
      end else if (wb_valid && wb_ready) begin
         wb_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/comet_ii_exec_ctrl.sv
// comet_ii_exec_ctrl: COMET II execute controller (IDLE -> EXEC -> [WB] -> IDLE).
// Accepts one decoded op per IDLE cycle, drives the external combinational
// ALU for exactly one EXEC cycle, captures its result/flags, and delivers
// GR writeback over a valid/ready handshake.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            issue handshake from decode
//   req_op, req_dst, req_a, req_b  op code, destination GR, operands
//   alu_op, alu_in0, alu_in1       registered ALU drive (NOP outside EXEC)
//   alu_result, alu_fr             ALU result and {OF,SF,ZF}
//   wb_valid/wb_ready, wb_idx, wb_data   GR writeback handshake
//   fr                             architectural flag register {OF,SF,ZF}
//   busy                           high whenever not IDLE
// Optional: define COMET_II_EXEC_CNT_EN to add op_count, a saturating
// count of completed EXEC cycles.
module comet_ii_exec_ctrl
   import comet_ii_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [OP_W-1:0]   req_op,
   input  logic [IDX_W-1:0]  req_dst,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_in0,
   output logic [DATA_W-1:0] alu_in1,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [FR_W-1:0]   alu_fr,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [IDX_W-1:0]  wb_idx,
   output logic [DATA_W-1:0] wb_data,
   output logic [FR_W-1:0]   fr,
   output logic              busy
`ifdef COMET_II_EXEC_CNT_EN
   ,
   output logic [CNT_W-1:0]  op_count
`endif
);

   state_e           state;
   logic [OP_W-1:0]  op_q;
   logic [IDX_W-1:0] dst_q;
   logic             transfer;
   logic             load_wb;
   wb_payload_t      wb_payload;

   assign transfer        = req_valid && req_ready;
   assign load_wb         = (state == ST_EXEC) && op_has_wb(op_q);
   assign wb_payload.idx  = dst_q;
   assign wb_payload.data = alu_result;

   // Controller FSM; req_ready/busy are registered alongside the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         op_q      <= OP_NOP;
         dst_q     <= '0;
         alu_op    <= OP_NOP;
         alu_in0   <= '0;
         alu_in1   <= '0;
         fr        <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (transfer) begin
                  state     <= ST_EXEC;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  op_q      <= req_op;
                  dst_q     <= req_dst;
                  alu_op    <= req_op;
                  alu_in0   <= req_a;
                  // Shift distance saturates at the word width
                  alu_in1   <= op_is_shift(req_op) ? shift_clamp(req_b) : req_b;
               end
            end
            ST_EXEC: begin
               // Operands keep their last value; only the op drops to NOP
               alu_op <= OP_NOP;
               if (op_sets_fr(op_q)) begin
                  fr <= alu_fr;
               end
               if (op_has_wb(op_q)) begin
                  state <= ST_WB;
               end else begin
                  state     <= ST_IDLE;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            ST_WB: begin
               if (wb_ready) begin
                  state     <= ST_IDLE;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
               busy      <= 1'b0;
               alu_op    <= OP_NOP;
            end
         endcase
      end
   end

   comet_ii_exec_wb_reg u_wb_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_wb),
      .load_data (wb_payload),
      .wb_ready  (wb_ready),
      .wb_valid  (wb_valid),
      .wb_idx    (wb_idx),
      .wb_data   (wb_data)
   );

`ifdef COMET_II_EXEC_CNT_EN
   // Saturating count of EXEC cycles, NOPs included
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count <= '0;
      end else if ((state == ST_EXEC) && (op_count != '1)) begin
         op_count <= op_count + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_comet_ii_exec_ctrl.sv
// tb_comet_ii_exec_ctrl: scoreboard bench for comet_ii_exec_ctrl.
// Stimulus pushes hand-computed expectations into queues; a negedge monitor
// checks each EXEC cycle and each writeback as the DUT presents them.
// The combinational ALU is modelled here.
module tb_comet_ii_exec_ctrl;
   import comet_ii_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [2:0]  req_dst;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [3:0]  alu_op;
   logic [15:0] alu_in0;
   logic [15:0] alu_in1;
   logic [15:0] alu_result;
   logic [2:0]  alu_fr;
   logic        wb_valid;
   logic        wb_ready;
   logic [2:0]  wb_idx;
   logic [15:0] wb_data;
   logic [2:0]  fr;
   logic        busy;
`ifdef COMET_II_EXEC_CNT_EN
   logic [31:0] op_count;
`endif

   comet_ii_exec_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_dst    (req_dst),
      .req_a      (req_a),
      .req_b      (req_b),
      .alu_op     (alu_op),
      .alu_in0    (alu_in0),
      .alu_in1    (alu_in1),
      .alu_result (alu_result),
      .alu_fr     (alu_fr),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_idx     (wb_idx),
      .wb_data    (wb_data),
      .fr         (fr),
      .busy       (busy)
`ifdef COMET_II_EXEC_CNT_EN
      ,
      .op_count   (op_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] in1;
      logic [2:0]  fr;
      logic        wb;
      logic [2:0]  idx;
      logic [15:0] data;
   } exp_t;

   exp_t expq[$];
   exp_t wbq[$];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_xfer_cyc = 0;
   int xfer_cnt = 0;
   int stall_cnt = 0;
   int exp_ops = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic note_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: event not expected/seen (cyc %0d)", name, cyc);
   endtask

   // Reference ALU: returns {fr, result}; undefined ops give junk with all flags set
   function automatic logic [18:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
      logic [15:0] r;
      logic [16:0] s;
      logic        of;
      logic [2:0]  f;
      logic        arith;
      int          n;
      r = 16'hDEAD; s = '0; of = 1'b0; f = 3'b111; arith = 1'b1; n = int'(b);
      case (op)
         OP_LD:   r = b;
         OP_ADDA: begin r = a + b; of = (a[15] == b[15]) && (r[15] != a[15]); end
         OP_SUBA: begin r = a - b; of = (a[15] != b[15]) && (r[15] != a[15]); end
         OP_ADDL: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; of = s[16]; end
         OP_SUBL: begin r = a - b; of = (a < b); end
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_CPA:  begin arith = 1'b0; f = {1'b0, $signed(a) < $signed(b), a == b}; end
         OP_CPL:  begin arith = 1'b0; f = {1'b0, a < b, a == b}; end
         OP_SLA: begin
            s[14:0] = 15'(a[14:0] << n);
            r = {a[15], s[14:0]};
            if (n >= 1 && n <= 15) of = a[15-n];
         end
         OP_SRA: begin
            r = 16'($signed(a) >>> n);
            if (n >= 1 && n <= 16) of = a[n-1];
         end
         OP_SLL: begin
            r = 16'(a << n);
            if (n >= 1 && n <= 16) of = a[16-n];
         end
         OP_SRL: begin
            r = a >> n;
            if (n >= 1 && n <= 16) of = a[n-1];
         end
         default: arith = 1'b0;
      endcase
      if (arith) begin
         f[FR_OF] = of;
         f[FR_SF] = r[15];
         f[FR_ZF] = (r == 16'h0000);
      end
      return {f, r};
   endfunction

   always_comb {alu_fr, alu_result} = alu_model(alu_op, alu_in0, alu_in1);

   function automatic exp_t mk(input logic [3:0] op, input logic [2:0] idx, input logic [15:0] a,
                               input logic [15:0] in1, input logic [2:0] f, input logic wb,
                               input logic [15:0] data);
      exp_t e;
      e.op = op; e.idx = idx; e.a = a; e.in1 = in1; e.fr = f; e.wb = wb; e.data = data;
      return e;
   endfunction

   // Monitor: EXEC cycles, FR update one cycle later, writeback handshake
   logic       pend = 1'b0;
   logic [2:0] pend_fr = '0;
   logic       prev_wb = 1'b0;
   exp_t       me;

   always @(negedge clk) begin
      if (!rst_n) begin
         pend    = 1'b0;
         prev_wb = 1'b0;
      end else begin
         if (req_valid && req_ready) xfer_cnt++;
         if (pend) begin
            chk("fr", 32'(fr), 32'(pend_fr));
            pend = 1'b0;
         end
         if (alu_op != OP_NOP) begin
            if (expq.size() == 0) begin
               note_fail("unexpected_exec");
            end else begin
               me = expq.pop_front();
               chk("alu_op", 32'(alu_op), 32'(me.op));
               chk("alu_in0", 32'(alu_in0), 32'(me.a));
               chk("alu_in1", 32'(alu_in1), 32'(me.in1));
               chk("exec_busy", 32'(busy), 32'd1);
               chk("exec_req_ready", 32'(req_ready), 32'd0);
               chk("exec_latency", 32'(cyc - last_xfer_cyc), 32'd1);
               pend    = 1'b1;
               pend_fr = me.fr;
               if (me.wb) wbq.push_back(me);
            end
         end
         if (wb_valid) begin
            if (!prev_wb) chk("wb_latency", 32'(cyc - last_xfer_cyc), 32'd2);
            if (wbq.size() == 0) begin
               note_fail("unexpected_wb");
            end else begin
               chk("wb_idx", 32'(wb_idx), 32'(wbq[0].idx));
               chk("wb_data", 32'(wb_data), 32'(wbq[0].data));
               if (wb_ready) void'(wbq.pop_front());
               else stall_cnt++;
            end
         end
         prev_wb = wb_valid;
      end
   end

   // Present one request and hold it until the controller takes it
   task automatic issue(input exp_t e, input logic [15:0] b, input bit keep);
      int guard;
      guard     = 0;
      req_valid = 1'b1;
      req_op    = e.op;
      req_dst   = e.idx;
      req_a     = e.a;
      req_b     = b;
      while (!req_ready && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!req_ready) begin
         note_fail("issue_timeout");
      end else begin
         if (e.op != OP_NOP) expq.push_back(e);
         last_xfer_cyc = cyc;
         exp_ops++;
      end
      @(posedge clk); #1;
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
      chk({tag, "_fr"}, 32'(fr), 32'd0);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_wb_idx"}, 32'(wb_idx), 32'd0);
      chk({tag, "_wb_data"}, 32'(wb_data), 32'd0);
      chk({tag, "_alu_op"}, 32'(alu_op), 32'hF);
      chk({tag, "_alu_in0"}, 32'(alu_in0), 32'd0);
      chk({tag, "_alu_in1"}, 32'(alu_in1), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   int x1, x2, x3;

   initial begin
      rst_n = 1'b1; req_valid = 1'b0; req_op = OP_NOP; req_dst = '0;
      req_a = '0; req_b = '0; wb_ready = 1'b1;
      #1 rst_n = 1'b0;
      #2 chk_reset_state("reset");
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

      // Signed overflow into the sign bit
      issue(mk(OP_ADDA, 3'd1, 16'h7FFF, 16'h0001, 3'b110, 1'b1, 16'h8000), 16'h0001, 1'b0);

      // Compare: flags only, back in IDLE two cycles after transfer
      issue(mk(OP_CPL, 3'd0, 16'h0001, 16'h0002, 3'b010, 1'b0, 16'h0000), 16'h0002, 1'b0);
      @(negedge clk) chk("cpl_ready_exec", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      chk("cpl_ready_back", 32'(req_ready), 32'd1);
      chk("cpl_busy_back", 32'(busy), 32'd0);

      // Shift distance 0x25 clamps to 16
      issue(mk(OP_SLL, 3'd2, 16'h0001, 16'h0010, 3'b101, 1'b1, 16'h0000), 16'h0025, 1'b0);
      issue(mk(OP_SUBA, 3'd3, 16'h0005, 16'h0007, 3'b010, 1'b1, 16'hFFFE), 16'h0007, 1'b0);

      // NOP and undefined op leave fr at 3'b010 and never write back
      issue(mk(OP_NOP, 3'd4, 16'h1111, 16'h2222, 3'b010, 1'b0, 16'h0000), 16'h2222, 1'b0);
      issue(mk(4'hE, 3'd4, 16'h1234, 16'h0040, 3'b010, 1'b0, 16'h0000), 16'h0040, 1'b0);

      // Writeback stalled for 4 cycles
      wb_ready  = 1'b0;
      stall_cnt = 0;
      issue(mk(OP_LD, 3'd5, 16'h1234, 16'h0000, 3'b001, 1'b1, 16'h0000), 16'h0000, 1'b0);
      repeat (5) @(posedge clk);
      #1 wb_ready = 1'b1;
      @(posedge clk); #1;
      chk("ld_stall_cycles", 32'(stall_cnt), 32'd4);
      chk("ld_ready_back", 32'(req_ready), 32'd1);
      chk("ld_wb_valid_drop", 32'(wb_valid), 32'd0);

      // Reset while XOR sits in WB
      wb_ready = 1'b0;
      issue(mk(OP_XOR, 3'd6, 16'hF0F0, 16'h0FF0, 3'b010, 1'b1, 16'hFF00), 16'h0FF0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 chk_reset_state("midwb");
      wbq.delete();
      expq.delete();
      exp_ops = 0;
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      wb_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("post_reset_wb_valid", 32'(wb_valid), 32'd0);
      chk("post_reset_fr", 32'(fr), 32'd0);

      // Three ops with req_valid held high throughout
      xfer_cnt = 0;
      issue(mk(OP_ADDL, 3'd1, 16'hFFFF, 16'h0001, 3'b101, 1'b1, 16'h0000), 16'h0001, 1'b1);
      x1 = last_xfer_cyc;
      issue(mk(OP_SRA, 3'd2, 16'h8000, 16'h0003, 3'b010, 1'b1, 16'hF000), 16'h0003, 1'b1);
      x2 = last_xfer_cyc;
      issue(mk(OP_AND, 3'd7, 16'h0F0F, 16'h00FF, 3'b000, 1'b1, 16'h000F), 16'h00FF, 1'b0);
      x3 = last_xfer_cyc;
      repeat (6) @(posedge clk);
      #1;
      chk("b2b_transfers", 32'(xfer_cnt), 32'd3);
      chk("b2b_spacing_1", 32'(x2 - x1), 32'd3);
      chk("b2b_spacing_2", 32'(x3 - x2), 32'd3);
`ifdef COMET_II_EXEC_CNT_EN
      chk("op_count", op_count, 32'(exp_ops));
`endif

      chk("exec_queue_drained", 32'(expq.size()), 32'd0);
      chk("wb_queue_drained", 32'(wbq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
